// File: rtl/display_fetch_arbiter.sv
// Display line fetch / decoder write arbiter for one memory port.
// Optional define FETCH_UNDERRUN_CNT_EN builds the saturating underrun counter.
module display_fetch_arbiter #(
    parameter int LINE_WORDS = 100,
    parameter int BURST_LEN  = 8,
    parameter int V_ACTIVE   = 600,
    parameter int V_TOTAL    = 628,
    parameter int FETCH_COL  = 1000
) (
    input  logic        video_clock,
    input  logic        reset,
    input  logic [10:0] column_count,
    input  logic [9:0]  row_count,
    input  logic [19:0] frame_base,
    input  logic        wr_req,
    input  logic [19:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [19:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        lb_we,
    output logic [7:0]  lb_addr,
    output logic [31:0] lb_data,
    output logic        underrun,
    output logic [15:0] underrun_count
);

    localparam logic [10:0] COL_TRIG   = 11'(FETCH_COL);
    localparam logic [9:0]  ROW_FMAX   = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  ROW_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  ROW_SAMPLE = 10'(V_ACTIVE);
    localparam logic [7:0]  LAST_IDX   = 8'(LINE_WORDS - 1);
    localparam logic [5:0]  LAST_BURST = 6'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [19:0] base_q;
    logic [19:0] line_q;
    logic [7:0]  idx_q;
    logic [5:0]  burst_q;
    logic        underrun_q;

    logic        trigger;
    logic [9:0]  next_line;
    logic [19:0] line_nxt;
    logic        wr_acc;
    logic        idx_clr;
    logic        idx_inc;
    logic        burst_clr;
    logic        burst_inc;
    logic        line_load;
    logic        und_set;

    assign trigger = (column_count == COL_TRIG) &&
                     ((row_count < ROW_FMAX) || (row_count == ROW_LAST));

    assign next_line = (row_count == ROW_LAST) ? 10'd0
                                               : row_count + 10'd1;

    assign line_nxt = base_q + {10'd0, next_line} * 20'(LINE_WORDS);

    assign wr_acc = wr_req & mem_ack;

    // Next state, memory port muxing and datapath controls.
    always_comb begin
        state_nxt = state;
        wr_ack    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        lb_we     = 1'b0;
        lb_addr   = '0;
        lb_data   = '0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        burst_clr = 1'b0;
        burst_inc = 1'b0;
        line_load = 1'b0;
        und_set   = 1'b0;
        unique case (state)
            IDLE: begin
                if (trigger) begin
                    line_load = 1'b1;
                    idx_clr   = 1'b1;
                    state_nxt = FETCH;
                end else if (wr_req) begin
                    burst_clr = 1'b1;
                    state_nxt = WRITE;
                end
            end
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = line_q + {12'd0, idx_q};
                if (mem_ack) begin
                    lb_we   = 1'b1;
                    lb_addr = idx_q;
                    lb_data = mem_rdata;
                end
                if (trigger) begin
                    line_load = 1'b1;
                    idx_clr   = 1'b1;
                    und_set   = !(mem_ack && (idx_q == LAST_IDX));
                end else if (mem_ack) begin
                    if (idx_q == LAST_IDX) begin
                        idx_clr   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            WRITE: begin
                mem_req   = wr_req;
                mem_we    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
                wr_ack    = wr_acc;
                burst_inc = wr_acc;
                if (trigger) begin
                    line_load = 1'b1;
                    idx_clr   = 1'b1;
                    burst_clr = 1'b1;
                    state_nxt = FETCH;
                end else if (wr_acc && (burst_q == LAST_BURST)) begin
                    burst_clr = 1'b1;
                    state_nxt = IDLE;
                end else if (!wr_req) begin
                    burst_clr = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge video_clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame base capture at start of vertical blanking.
    always_ff @(posedge video_clock or posedge reset) begin
        if (reset) begin
            base_q <= '0;
        end else if ((row_count == ROW_SAMPLE) && (column_count == 11'd0)) begin
            base_q <= frame_base;
        end
    end

    // Line address, word index, burst count and sticky underrun.
    always_ff @(posedge video_clock or posedge reset) begin
        if (reset) begin
            line_q     <= '0;
            idx_q      <= '0;
            burst_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            if (line_load) begin
                line_q <= line_nxt;
            end
            if (idx_clr) begin
                idx_q <= '0;
            end else if (idx_inc) begin
                idx_q <= idx_q + 8'd1;
            end
            if (burst_clr) begin
                burst_q <= '0;
            end else if (burst_inc) begin
                burst_q <= burst_q + 6'd1;
            end
            if (und_set) begin
                underrun_q <= 1'b1;
            end
        end
    end

    assign underrun = underrun_q;

`ifdef FETCH_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;

    // Saturating count of fetch restarts.
    always_ff @(posedge video_clock or posedge reset) begin
        if (reset) begin
            ucnt_q <= '0;
        end else if (und_set && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign underrun_count = ucnt_q;
`else
    assign underrun_count = 16'd0;
`endif

endmodule

// File: tb/tb_display_fetch_arbiter.sv
// Bench for display_fetch_arbiter: vector table, directed
// sequences and a randomized run against a behavioural model.
module tb_display_fetch_arbiter;

    localparam int LW = 100;
    localparam int BL = 8;

`ifdef FETCH_UNDERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam logic [15:0] CNT1 = CNT_EN ? 16'd1 : 16'd0;

    logic        video_clock = 1'b0;
    logic        reset;
    logic [10:0] column_count;
    logic [9:0]  row_count;
    logic [19:0] frame_base;
    logic        wr_req;
    logic [19:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        mem_req;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        lb_we;
    logic [7:0]  lb_addr;
    logic [31:0] lb_data;
    logic        underrun;
    logic [15:0] underrun_count;

    int total = 0;
    int bad   = 0;

    display_fetch_arbiter #(
        .LINE_WORDS(LW),
        .BURST_LEN (BL),
        .V_ACTIVE  (600),
        .V_TOTAL   (628),
        .FETCH_COL (1000)
    ) dut (
        .video_clock   (video_clock),
        .reset         (reset),
        .column_count  (column_count),
        .row_count     (row_count),
        .frame_base    (frame_base),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .lb_we         (lb_we),
        .lb_addr       (lb_addr),
        .lb_data       (lb_data),
        .underrun      (underrun),
        .underrun_count(underrun_count)
    );

    always #5 video_clock = ~video_clock;

    typedef struct {
        logic [10:0]  col;
        logic [9:0]   row;
        logic         wr;
        logic [19:0]  waddr;
        logic [31:0]  wdata;
        logic         ack;
        logic [31:0]  rdata;
        logic [127:0] exp;
    } vec_t;

    vec_t tv[9];

    function automatic logic [127:0] outv(
        input logic wa, input logic rq, input logic we,
        input logic [19:0] a, input logic [31:0] wd,
        input logic lw, input logic [7:0] la,
        input logic [31:0] ld, input logic u,
        input logic [15:0] c);
        return {15'd0, wa, rq, we, a, wd, lw, la, ld, u, c};
    endfunction

    function automatic logic [127:0] dut_out();
        return {15'd0, wr_ack, mem_req, mem_we, mem_addr,
                mem_wdata, lb_we, lb_addr, lb_data,
                underrun, underrun_count};
    endfunction

    function automatic vec_t mk(
        input logic [10:0] col, input logic [9:0] row,
        input logic wr, input logic [19:0] waddr,
        input logic [31:0] wdata, input logic ack,
        input logic [31:0] rdata, input logic [127:0] exp);
        vec_t v;
        v.col = col; v.row = row; v.wr = wr;
        v.waddr = waddr; v.wdata = wdata; v.ack = ack;
        v.rdata = rdata; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string nm,
                         input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        column_count = 11'd0;
        row_count    = 10'd10;
        wr_req       = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
    endtask

    task automatic adv();
        @(posedge video_clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_in();
        @(posedge video_clock);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge video_clock) begin
        if (!reset) begin
            total++;
            if (lb_we && wr_ack) begin
                bad++;
                $display("FAIL lb_we_wr_ack_overlap act=1 exp=0");
            end
        end
    end

    // behavioural model state
    int          m_left;
    logic [19:0] m_faddr;
    bit          m_wr_on;
    int          m_bdone;
    logic [19:0] m_base;
    bit          m_und;
    int          m_cnt;

    task automatic model_init();
        m_left = 0; m_faddr = '0; m_wr_on = 0;
        m_bdone = 0; m_base = '0; m_und = 0; m_cnt = 0;
    endtask

    task automatic model_cycle(output logic [127:0] e);
        bit trig;
        int nl;
        int w;
        logic [19:0] na;
        logic wa = 0, rq = 0, we = 0, lw = 0;
        logic [19:0] a = '0;
        logic [31:0] wd = '0, ld = '0;
        logic [7:0] la = '0;
        trig = (column_count == 11'd1000) &&
               (row_count < 10'd599 || row_count == 10'd627);
        nl = (row_count == 10'd627) ? 0 : int'(row_count) + 1;
        na = 20'(int'(m_base) + nl * LW);
        if (m_left > 0) begin
            w = LW - m_left;
            rq = 1; a = m_faddr + 20'(w);
            if (mem_ack) begin
                lw = 1; la = 8'(w); ld = mem_rdata;
            end
        end else if (m_wr_on) begin
            rq = wr_req; we = 1; a = wr_addr; wd = wr_data;
            wa = wr_req && mem_ack;
        end
        e = outv(wa, rq, we, a, wd, lw, la, ld, m_und, 16'(m_cnt));
        if (m_left > 0) begin
            if (mem_ack) m_left--;
            if (trig) begin
                if (m_left > 0) begin
                    m_und = 1;
                    if (CNT_EN && m_cnt < 65535) m_cnt++;
                end
                m_left = LW; m_faddr = na;
            end
        end else if (m_wr_on) begin
            if (wr_req && mem_ack) m_bdone++;
            if (trig) begin
                m_wr_on = 0; m_left = LW; m_faddr = na;
            end else if (m_bdone == BL || !wr_req) begin
                m_wr_on = 0;
            end
        end else begin
            if (trig) begin
                m_left = LW; m_faddr = na;
            end else if (wr_req) begin
                m_wr_on = 1; m_bdone = 0;
            end
        end
        if (row_count == 10'd600 && column_count == 11'd0)
            m_base = frame_base;
    endtask

    initial begin
        int nlb;
        int nwa;
        int acks;
        int p;
        int lens[3];
        logic [127:0] hb;
        logic [127:0] eb;
        logic [127:0] e;

        tv[0] = mk(0, 10, 0, 0, 0, 0, 0, 128'd0);
        tv[1] = mk(0, 10, 1, 20'h12345, 32'hDEADBEEF, 0, 0, 128'd0);
        tv[2] = mk(0, 10, 1, 20'h12345, 32'hDEADBEEF, 1, 0,
                   outv(1, 1, 1, 20'h12345, 32'hDEADBEEF,
                        0, 0, 0, 0, 0));
        tv[3] = mk(0, 10, 1, 20'h12345, 32'hDEADBEEF, 0, 0,
                   outv(0, 1, 1, 20'h12345, 32'hDEADBEEF,
                        0, 0, 0, 0, 0));
        tv[4] = mk(1000, 10, 1, 20'h12345, 32'hDEADBEEF, 1, 0,
                   outv(1, 1, 1, 20'h12345, 32'hDEADBEEF,
                        0, 0, 0, 0, 0));
        tv[5] = mk(1001, 10, 1, 20'h12345, 32'hDEADBEEF, 1,
                   32'hA5A5A5A5,
                   outv(0, 1, 0, 20'h0044C, 0,
                        1, 0, 32'hA5A5A5A5, 0, 0));
        tv[6] = mk(1001, 10, 1, 20'h12345, 32'hDEADBEEF, 0, 0,
                   outv(0, 1, 0, 20'h0044D, 0, 0, 0, 0, 0, 0));
        tv[7] = mk(1000, 20, 0, 0, 0, 0, 0,
                   outv(0, 1, 0, 20'h0044D, 0, 0, 0, 0, 0, 0));
        tv[8] = mk(1001, 20, 0, 0, 0, 1, 32'h11,
                   outv(0, 1, 0, 20'h00834, 0,
                        1, 0, 32'h11, 1, CNT1));

        // reset state with active-looking inputs
        reset = 1'b1;
        idle_in();
        frame_base = '0;
        wr_req = 1'b1;
        mem_ack = 1'b1;
        @(negedge video_clock);
        check("reset_state", dut_out(), 128'd0);
        do_reset();

        // vector table
        for (int i = 0; i < 9; i++) begin
            column_count = tv[i].col;
            row_count    = tv[i].row;
            wr_req       = tv[i].wr;
            wr_addr      = tv[i].waddr;
            wr_data      = tv[i].wdata;
            mem_ack      = tv[i].ack;
            mem_rdata    = tv[i].rdata;
            @(negedge video_clock);
            check($sformatf("vec%0d", i), dut_out(), tv[i].exp);
            adv();
        end

        // full line fetch with ack tied high
        do_reset();
        frame_base = 20'h10000;
        row_count = 10'd600;
        adv();
        frame_base = 20'h0F0F0;
        row_count = 10'd5;
        column_count = 11'd1000;
        mem_ack = 1'b1;
        adv();
        column_count = 11'd1001;
        for (int i = 0; i < LW; i++) begin
            mem_rdata = 32'(i * 3 + 7);
            @(negedge video_clock);
            check("line_word", dut_out(),
                  outv(0, 1, 0, 20'h10000 + 20'(600 + i), 0,
                       1, 8'(i), 32'(i * 3 + 7), 0, 0));
            adv();
        end
        @(negedge video_clock);
        check("line_done_idle", dut_out(), 128'd0);

        // write bursts of 8, 8, 4
        do_reset();
        wr_req = 1'b1;
        wr_addr = 20'h00ABC;
        wr_data = 32'h0BADF00D;
        mem_ack = 1'b1;
        acks = 0;
        p = 0;
        hb = '0;
        for (int i = 0; i < 60 && acks < 20; i++) begin
            @(negedge video_clock);
            hb[p] = wr_ack;
            p++;
            if (wr_ack) acks++;
            adv();
        end
        wr_req = 1'b0;
        lens = '{8, 8, 4};
        eb = '0;
        p = 1;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < lens[b]; k++) begin
                eb[p] = 1'b1;
                p++;
            end
            p++;
        end
        check("burst_acks", 128'(acks), 128'(20));
        check("burst_pattern", hb, eb);

        // trigger beats simultaneous write request
        do_reset();
        row_count = 10'd5;
        column_count = 11'd1000;
        wr_req = 1'b1;
        mem_ack = 1'b1;
        @(negedge video_clock);
        check("tie_idle", dut_out(), 128'd0);
        adv();
        column_count = 11'd1001;
        nlb = 0;
        nwa = 0;
        for (int i = 0; i < LW; i++) begin
            @(negedge video_clock);
            nlb += int'(lb_we);
            nwa += int'(wr_ack);
            adv();
        end
        check("tie_reads", 128'(nlb), 128'(LW));
        check("tie_no_wr_ack", 128'(nwa), 128'd0);
        @(negedge video_clock);
        check("tie_gap", {126'd0, mem_req, wr_ack}, 128'd0);
        adv();
        @(negedge video_clock);
        check("tie_write", 128'(wr_ack), 128'd1);

        // underrun from retrigger with memory stalled
        do_reset();
        row_count = 10'd3;
        column_count = 11'd1000;
        adv();
        column_count = 11'd1001;
        repeat (5) adv();
        row_count = 10'd4;
        column_count = 11'd1000;
        @(negedge video_clock);
        check("und_before", 128'(underrun), 128'd0);
        adv();
        column_count = 11'd1001;
        @(negedge video_clock);
        check("und_after", dut_out(),
              outv(0, 1, 0, 20'd500, 0, 0, 0, 0, 1, CNT1));

        // base sampled at row 600 used for line 0
        do_reset();
        frame_base = 20'h20000;
        row_count = 10'd600;
        adv();
        frame_base = 20'h33333;
        row_count = 10'd100;
        adv();
        row_count = 10'd627;
        column_count = 11'd1000;
        adv();
        column_count = 11'd1001;
        @(negedge video_clock);
        check("base_line0", dut_out(),
              outv(0, 1, 0, 20'h20000, 0, 0, 0, 0, 0, 0));

        // async reset in the middle of a fetch
        do_reset();
        row_count = 10'd5;
        column_count = 11'd1000;
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFE0000;
        adv();
        column_count = 11'd1001;
        repeat (40) adv();
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", dut_out(), 128'd0);
        @(posedge video_clock);
        #1;
        reset = 1'b0;
        nlb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge video_clock);
            nlb += int'(lb_we);
            adv();
        end
        check("post_reset_quiet", 128'(nlb), 128'd0);
        column_count = 11'd1000;
        adv();
        column_count = 11'd1001;
        @(negedge video_clock);
        check("post_reset_fetch", dut_out(),
              outv(0, 1, 0, 20'd600, 0, 1, 0, 32'hCAFE0000, 0, 0));

        // randomized run against the model
        do_reset();
        model_init();
        for (int i = 0; i < 5000; i++) begin
            case ($urandom_range(0, 63))
                0: column_count = 11'd1000;
                1: column_count = 11'd0;
                default: column_count = 11'($urandom_range(0, 1343));
            endcase
            case ($urandom_range(0, 7))
                0: row_count = 10'd598;
                1: row_count = 10'd599;
                2: row_count = 10'd600;
                3: row_count = 10'd627;
                default: row_count = 10'($urandom_range(0, 627));
            endcase
            if ($urandom_range(0, 15) == 0)
                frame_base = 20'($urandom);
            wr_req    = ($urandom_range(0, 3) != 0);
            wr_addr   = 20'($urandom);
            wr_data   = $urandom;
            mem_ack   = ($urandom_range(0, 3) != 0);
            mem_rdata = $urandom;
            @(negedge video_clock);
            model_cycle(e);
            check("random", dut_out(), e);
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_fetch_arbiter.md
DISPLAY_FETCH_ARBITER -- requirements
Module: display_fetch_arbiter

Interface
REQ-001 The block SHALL use one clock, video_clock; reset SHALL be named reset and SHALL be asynchronous and active-high.
REQ-002 Parameter LINE_WORDS, default 100: memory words fetched per active display line (1..256).
REQ-003 Parameter BURST_LEN, default 8: maximum consecutive decoder write words per grant (1..64).
REQ-004 Parameter V_ACTIVE, default 600, and V_TOTAL, default 628: active lines and total lines per frame.
REQ-005 Parameter FETCH_COL, default 1000: column at which the next line's fetch is triggered.
REQ-006 Ports (name  direction  width  meaning):
- video_clock  in  1  pixel clock
- reset  in  1  async active-high reset
- column_count  in  11  current pixel column from timing generator
- row_count  in  10  current line from timing generator
- frame_base  in  20  word address of the frame to display
- wr_req  in  1  decoder write request
- wr_addr  in  20  decoder write word address
- wr_data  in  32  decoder write data
- wr_ack  out  1  decoder word accepted
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  20  memory word address
- mem_wdata  out  32  memory write data
- mem_ack  in  1  memory accepted word; read data valid same cycle
- mem_rdata  in  32  memory read data
- lb_we  out  1  line-buffer write strobe
- lb_addr  out  8  line-buffer word index
- lb_data  out  32  line-buffer write data
- underrun  out  1  sticky: fetch retriggered before completion
- underrun_count  out  16  saturating underrun event count

Function
REQ-007 Fetch trigger SHALL fire in the cycle column_count == FETCH_COL and (row_count < V_ACTIVE-1 or row_count == V_TOTAL-1).
REQ-008 frame_base SHALL be sampled into an internal base register when row_count == V_ACTIVE and column_count == 0; the line address SHALL be base + next_line*LINE_WORDS, where next_line is row_count+1, or 0 when row_count == V_TOTAL-1.
REQ-009 States SHALL be IDLE, FETCH, WRITE.
REQ-010 IDLE: trigger -> FETCH; else wr_req -> WRITE; trigger wins when simultaneous with wr_req.
REQ-011 FETCH: mem_req=1, mem_we=0, mem_addr = line address + word index; each mem_ack SHALL produce lb_we=1, lb_addr=index, lb_data=mem_rdata in the same cycle and increment index; ack of word LINE_WORDS-1 -> IDLE.
REQ-012 WRITE: mem_req=wr_req, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=mem_ack; leave to IDLE after BURST_LEN acks, or when wr_req=0 with no ack in that cycle.
REQ-013 A trigger during WRITE SHALL complete the current word (if acked that cycle) then move to FETCH next cycle, abandoning the burst; decoder sees wr_ack only for accepted words.
REQ-014 A trigger during FETCH SHALL set underrun, restart the index at 0 with the new line address, and remain in FETCH.
REQ-015 mem_req SHALL be 0 in IDLE; lb_we and wr_ack SHALL never be 1 in the same cycle.
REQ-016 Word index and burst count SHALL not wrap; index range 0..LINE_WORDS-1.

Reset
REQ-017 Reset SHALL force IDLE, base=0, index=0, burst count=0, all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, wr_ack, lb_we, lb_addr, lb_data, underrun, underrun_count).
REQ-018 Reset mid-FETCH or mid-WRITE SHALL abandon the transfer immediately; no further lb_we or wr_ack until a new trigger/request after release.

Configuration
REQ-019 With FETCH_UNDERRUN_CNT_EN defined, underrun_count SHALL increment by 1 on each REQ-014 event, saturating at 16'hFFFF; without it, underrun_count SHALL be constant 0 and the counter SHALL not be built; underrun flag behaviour is identical in both cases.

Verification
REQ-020 Reset release, mem_ack tied 1, row 5, column reaches 1000 -> 100 consecutive lb_we pulses, lb_addr 0..99, mem_addr base+600..base+699.
REQ-021 wr_req held 20 cycles in IDLE, mem_ack=1 -> wr_ack in bursts of 8, 8, 4 with one IDLE cycle between bursts.
REQ-022 Trigger and wr_req in same cycle -> FETCH entered; wr_ack stays 0 until 100 reads complete.
REQ-023 mem_ack held 0 through two triggers (rows 3, 4) -> underrun=1, index restarts 0, mem_addr = base+5*100; underrun_count=1 with macro, 0 without.
REQ-024 frame_base changed at row 100 -> fetch for line 0 (row 627) still uses base sampled at row 600.
REQ-025 Reset asserted mid-FETCH at word 40 -> all outputs 0 asynchronously; no lb_we until next trigger.
